// File: rtl/spi_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_pkg
// Description : Shared types and constants for the SPI mode-0 transmit master.
//               The optional macro SPI_TX_LSB_FIRST_EN is consumed in
//               spi_tx_master.sv.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_tx_pkg;

  // Word width, matching the upstream FIFO data width
  localparam int SPI_DATA_WIDTH = 32;

  // Counter widths
  localparam int DIV_CNT_W = 8;
  localparam int BIT_CNT_W = 6;

  // Index of the last bit of a word, as seen by bit_cnt
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SPI_DATA_WIDTH - 1);

  // Transmit FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : Phase counter for the SPI master. Counts CLK cycles from 0 up
//               to a terminal value and emits a one-cycle tick on the
//               terminal count, then restarts from 0. Used both for SCLK
//               half-periods and for the inter-word gap.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div
  import spi_tx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DIV_CNT_W-1:0] terminal,
  output logic                 tick
);

  logic [DIV_CNT_W-1:0] cnt_q;
  logic [DIV_CNT_W-1:0] cnt_d;

  // The tick marks the last cycle of a phase; clear holds the count at zero
  assign tick = !clear && (cnt_q == terminal);

  // Next count: restart after the terminal value so the counter never passes it
  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_tx_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_master
// Description : SPI mode-0 transmit engine. Pops 32-bit words from an
//               unbuffered FIFO read port and shifts them out on MOSI with a
//               divided SCLK, framing each word with CS_N and following it
//               with a CS_N-high gap.
//               Optional macro SPI_TX_LSB_FIRST_EN: when defined, words are
//               shifted LSB-first; otherwise MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_master
  import spi_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      ENABLE,
  input  logic                      FIFO_EMPTY,
  input  logic [SPI_DATA_WIDTH-1:0] FIFO_DATA,
  output logic                      FIFO_READ,
  output logic                      SCLK,
  output logic                      MOSI,
  output logic                      CS_N,
  output logic                      BUSY,
  output logic                      WORD_DONE
);

  localparam logic [DIV_CNT_W-1:0] DIV_TERM = DIV_CNT_W'(CLK_DIV - 1);
  localparam logic [DIV_CNT_W-1:0] GAP_TERM = DIV_CNT_W'(GAP_CYCLES - 1);

  state_e                    state_q,     state_d;
  logic [SPI_DATA_WIDTH-1:0] shreg_q,     shreg_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic                      sclk_q,      sclk_d;
  logic                      cs_n_q,      cs_n_d;
  logic                      busy_q,      busy_d;
  logic                      word_done_q, word_done_d;

  logic                      load;
  logic                      div_clear;
  logic [DIV_CNT_W-1:0]      div_term;
  logic                      div_tick;
  logic [SPI_DATA_WIDTH-1:0] shifted;

  // MOSI is taken straight from the shift register's outgoing end, so it is a
  // flop output; clearing the register at word end drives MOSI low in the gap.
`ifdef SPI_TX_LSB_FIRST_EN
  assign shifted = {1'b0, shreg_q[SPI_DATA_WIDTH-1:1]};
  assign MOSI    = shreg_q[0];
`else
  assign shifted = {shreg_q[SPI_DATA_WIDTH-2:0], 1'b0};
  assign MOSI    = shreg_q[SPI_DATA_WIDTH-1];
`endif

  // A word starts only from IDLE; the pop strobe is held off during reset
  assign load      = (state_q == IDLE) && ENABLE && !FIFO_EMPTY;
  assign FIFO_READ = load && RST_N;

  assign SCLK      = sclk_q;
  assign CS_N      = cs_n_q;
  assign BUSY      = busy_q;
  assign WORD_DONE = word_done_q;

  spi_clk_div u_clk_div (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clear    (div_clear),
    .terminal (div_term),
    .tick     (div_tick)
  );

  // Next-state and output logic for the load / shift / gap sequence
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    word_done_d = 1'b0;
    div_clear   = 1'b0;
    div_term    = DIV_TERM;

    case (state_q)
      IDLE: begin
        // Hold the divider at zero so the first low phase is a full one
        div_clear = 1'b1;
        if (load) begin
          state_d   = SHIFT;
          shreg_d   = FIFO_DATA;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end

      SHIFT: begin
        if (div_tick) begin
          if (!sclk_q) begin
            // End of low phase: rising edge, slave samples MOSI
            sclk_d = 1'b1;
          end else begin
            // End of high phase: falling edge and advance to the next bit
            sclk_d    = 1'b0;
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              // bit_cnt parks at 32 until the next load
              state_d     = GAP;
              shreg_d     = '0;
              cs_n_d      = 1'b1;
              word_done_d = 1'b1;
            end
          end
        end
      end

      GAP: begin
        div_term = GAP_TERM;
        if (div_tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_tx_master
// Description : Self-checking bench for spi_tx_master. A queue models the
//               FIFO; a negedge monitor reassembles words from SCLK/MOSI and
//               the tasks compare them against an expected-word queue.
//               Honours SPI_TX_LSB_FIRST_EN for the expected bit order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_tx_master;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;
  localparam int GAPC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic        sel    = 1'b0;
  logic        f_empty = 1'b1;
  logic [31:0] f_data  = '0;
  logic        e0, e1;
  logic        rd0, sclk0, mosi0, cs0, busy0, done0;
  logic        rd1, sclk1, mosi1, cs1, busy1, done1;
  logic        m_rd, m_sclk, m_mosi, m_cs_n, m_done;

  // Only the selected DUT sees the FIFO; the other one sees it empty
  assign e0 = sel ? 1'b1 : f_empty;
  assign e1 = sel ? f_empty : 1'b1;

  spi_tx_master #(.CLK_DIV(DIV0), .GAP_CYCLES(GAPC)) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .FIFO_EMPTY(e0), .FIFO_DATA(f_data),
    .FIFO_READ(rd0), .SCLK(sclk0), .MOSI(mosi0), .CS_N(cs0), .BUSY(busy0), .WORD_DONE(done0)
  );

  spi_tx_master #(.CLK_DIV(DIV1), .GAP_CYCLES(GAPC)) dut_div1 (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .FIFO_EMPTY(e1), .FIFO_DATA(f_data),
    .FIFO_READ(rd1), .SCLK(sclk1), .MOSI(mosi1), .CS_N(cs1), .BUSY(busy1), .WORD_DONE(done1)
  );

  assign m_rd   = sel ? rd1   : rd0;
  assign m_sclk = sel ? sclk1 : sclk0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_cs_n = sel ? cs1   : cs0;
  assign m_done = sel ? done1 : done0;

  typedef struct {
    logic [31:0] data;
    int          bits;
    int          low;
  } rx_t;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  rx_t         rx_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state
  int          rd_cycles = 0, done_cycles = 0, sclk_rises = 0, words_seen = 0;
  int          no_toggle = 0, cs_low = 0, cs_high = 0, last_high = 0, bits = 0;
  logic [31:0] rx = '0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1, rd_latch = 1'b0;

  // Expected on-wire order: the monitor assembles first-sent bit as MSB
  function automatic logic [31:0] wire_order(input logic [31:0] w);
    logic [31:0] r;
`ifdef SPI_TX_LSB_FIRST_EN
    for (int i = 0; i < 32; i++) r[31-i] = w[i];
`else
    r = w;
`endif
    return r;
  endfunction

  // FIFO model: pop on the edge after a sampled FIFO_READ, refresh outputs after the edge
  always @(posedge clk) begin
    if (rd_latch && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
    if (fifo_q.size() > 0) begin
      f_empty = 1'b0;
      f_data  = fifo_q[0];
    end else begin
      f_empty = 1'b1;
      f_data  = '0;
    end
  end

  // Bus monitor on the falling edge, away from DUT output changes
  always @(negedge clk) begin
    rx_t r;
    rd_latch = m_rd;
    if (!rst_n) begin
      prev_sclk = 1'b0;
      prev_cs   = 1'b1;
      bits      = 0;
      cs_low    = 0;
      cs_high   = 0;
    end else begin
      if (m_rd)   rd_cycles++;
      if (m_done) done_cycles++;
      if (m_sclk && !prev_sclk) begin
        rx = {rx[30:0], m_mosi};
        bits++;
        sclk_rises++;
      end
      if (!m_cs_n) begin
        cs_low++;
        if (prev_cs) last_high = cs_high;
        else if (m_sclk == prev_sclk) no_toggle++;
      end else begin
        if (!prev_cs) begin
          r.data = rx; r.bits = bits; r.low = cs_low;
          rx_q.push_back(r);
          words_seen++;
          bits    = 0;
          cs_low  = 0;
          cs_high = 1;
        end else begin
          cs_high++;
        end
      end
      prev_sclk = m_sclk;
      prev_cs   = m_cs_n;
    end
  end

  task automatic push_word(input logic [31:0] w, input bit expect_it);
    fifo_q.push_back(w);
    if (expect_it) exp_q.push_back(wire_order(w));
  endtask

  task automatic wait_words(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (words_seen >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (sclk_rises >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; sel = 1'b0;
    push_word(32'hA5A5_0F0F, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (rd0 !== 1'b0)   $display("FAIL reset_fifo_read: got %b want 0", rd0);   else n_pass++;
    n_checks++; if (cs0 !== 1'b1)   $display("FAIL reset_cs_n: got %b want 1", cs0);        else n_pass++;
    n_checks++; if (sclk0 !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk0);      else n_pass++;
    n_checks++; if (mosi0 !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi0);      else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0);      else n_pass++;
    n_checks++; if (done0 !== 1'b0) $display("FAIL reset_word_done: got %b want 0", done0); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    int r0, d0, s0, w0;
    bit ok;
    rx_t r;
    logic [31:0] e;
    r0 = rd_cycles; d0 = done_cycles; s0 = sclk_rises; w0 = words_seen;
    enable = 1'b1;
    wait_words(w0 + 1, 400, ok);
    n_checks++; if (!ok) $display("FAIL single_timeout: words %0d want %0d", words_seen - w0, 1); else n_pass++;
    if (ok) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (r.data !== e) $display("FAIL single_data: got %h want %h", r.data, e); else n_pass++;
      n_checks++; if (r.low != 64*DIV0) $display("FAIL single_cs_low: got %0d want %0d", r.low, 64*DIV0); else n_pass++;
    end
    repeat (GAPC + 3) @(negedge clk);
    n_checks++; if (rd_cycles - r0 != 1)   $display("FAIL single_pops: got %0d want 1", rd_cycles - r0);     else n_pass++;
    n_checks++; if (done_cycles - d0 != 1) $display("FAIL single_done: got %0d want 1", done_cycles - d0);   else n_pass++;
    n_checks++; if (sclk_rises - s0 != 32) $display("FAIL single_rises: got %0d want 32", sclk_rises - s0);  else n_pass++;
    n_checks++; if (f_empty !== 1'b1)      $display("FAIL single_empty_after: got %b want 1", f_empty);      else n_pass++;
    n_checks++; if (busy0 !== 1'b0)        $display("FAIL single_busy_after: got %b want 0", busy0);         else n_pass++;
  endtask

  task automatic test_back_to_back();
    int r0, w0;
    bit ok;
    rx_t r;
    logic [31:0] e;
    r0 = rd_cycles; w0 = words_seen;
    push_word(32'h1234_5678, 1'b1);
    push_word(32'hDEAD_BEEF, 1'b1);
    wait_words(w0 + 2, 800, ok);
    n_checks++; if (!ok) $display("FAIL b2b_timeout: words %0d want %0d", words_seen - w0, 2); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      if (rx_q.size() > 0 && exp_q.size() > 0) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_checks++;
        if (r.data !== e || r.bits != 32 || r.low != 64*DIV0)
          $display("FAIL b2b_word%0d: got %h/%0d bits/%0d low want %h/32/%0d", k, r.data, r.bits, r.low, e, 64*DIV0);
        else n_pass++;
      end
    end
    n_checks++; if (last_high != GAPC + 1)  $display("FAIL b2b_cs_high_gap: got %0d want %0d", last_high, GAPC + 1); else n_pass++;
    n_checks++; if (rd_cycles - r0 != 2)    $display("FAIL b2b_pops: got %0d want 2", rd_cycles - r0);            else n_pass++;
  endtask

  task automatic test_empty_disable();
    int bad, r0;
    bad = 0;
    repeat (GAPC + 4) @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_rd !== 1'b0 || m_cs_n !== 1'b1 || m_sclk !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL empty_idle: got %0d bad cycles want 0", bad); else n_pass++;
    enable = 1'b0;
    r0 = rd_cycles;
    push_word(32'hFFFF_0000, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++; if (rd_cycles != r0)     $display("FAIL disabled_pop: got %0d pops want 0", rd_cycles - r0); else n_pass++;
    n_checks++; if (fifo_q.size() != 1)  $display("FAIL disabled_fifo: got %0d words want 1", fifo_q.size()); else n_pass++;
  endtask

  task automatic test_enable_drop();
    int r0, s0, w0;
    bit ok;
    rx_t r;
    logic [31:0] e;
    r0 = rd_cycles; s0 = sclk_rises; w0 = words_seen;
    push_word(32'h0BAD_F00D, 1'b0);
    enable = 1'b1;
    wait_rises(s0 + 10, 200, ok);
    enable = 1'b0;
    n_checks++; if (!ok) $display("FAIL drop_bit10_timeout: rises %0d want 10", sclk_rises - s0); else n_pass++;
    wait_words(w0 + 1, 400, ok);
    n_checks++; if (!ok) $display("FAIL drop_timeout: words %0d want 1", words_seen - w0); else n_pass++;
    if (ok) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (r.data !== e || r.bits != 32) $display("FAIL drop_word: got %h/%0d bits want %h/32", r.data, r.bits, e);
      else n_pass++;
    end
    repeat (60) @(negedge clk);
    n_checks++; if (rd_cycles - r0 != 1) $display("FAIL drop_pops: got %0d want 1", rd_cycles - r0);          else n_pass++;
    n_checks++; if (fifo_q.size() != 1) $display("FAIL drop_waiting: got %0d words want 1", fifo_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    int s0, w0;
    bit ok;
    rx_t r;
    logic [31:0] e;
    s0 = sclk_rises; w0 = words_seen;
    enable = 1'b1;
    wait_rises(s0 + 16, 200, ok);
    n_checks++; if (!ok) $display("FAIL rst_bit16_timeout: rises %0d want 16", sclk_rises - s0); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cs0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0 || busy0 !== 1'b0)
      $display("FAIL rst_async: got cs_n=%b sclk=%b mosi=%b busy=%b want 1 0 0 0", cs0, sclk0, mosi0, busy0);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (words_seen != w0) $display("FAIL rst_partial_word: got %0d words want 0", words_seen - w0); else n_pass++;
    push_word(32'hC3C3_3C3C, 1'b1);
    wait_words(w0 + 1, 400, ok);
    n_checks++; if (!ok) $display("FAIL rst_next_timeout: words %0d want 1", words_seen - w0); else n_pass++;
    if (ok) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (r.data !== e || r.bits != 32 || r.low != 64*DIV0)
        $display("FAIL rst_next_word: got %h/%0d bits/%0d low want %h/32/%0d", r.data, r.bits, r.low, e, 64*DIV0);
      else n_pass++;
    end
    n_checks++; if (rx_q.size() != 0) $display("FAIL rst_extra_words: got %0d want 0", rx_q.size()); else n_pass++;
  endtask

  task automatic test_clk_div1();
    int r0, s0, w0, t0;
    bit ok;
    rx_t r;
    logic [31:0] e;
    repeat (GAPC + 4) @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    r0 = rd_cycles; s0 = sclk_rises; w0 = words_seen; t0 = no_toggle;
    push_word(32'h8000_0001, 1'b1);
    wait_words(w0 + 1, 300, ok);
    n_checks++; if (!ok) $display("FAIL div1_timeout: words %0d want 1", words_seen - w0); else n_pass++;
    if (ok) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (r.data !== e)     $display("FAIL div1_data: got %h want %h", r.data, e);              else n_pass++;
      n_checks++; if (r.low != 64*DIV1) $display("FAIL div1_cs_low: got %0d want %0d", r.low, 64*DIV1);    else n_pass++;
    end
    repeat (GAPC + 3) @(negedge clk);
    n_checks++; if (no_toggle != t0)       $display("FAIL div1_toggle: got %0d stalls want 0", no_toggle - t0); else n_pass++;
    n_checks++; if (sclk_rises - s0 != 32) $display("FAIL div1_rises: got %0d want 32", sclk_rises - s0);      else n_pass++;
    n_checks++; if (rd_cycles - r0 != 1)   $display("FAIL div1_pops: got %0d want 1", rd_cycles - r0);         else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_empty_disable();
    test_enable_drop();
    test_reset_mid_word();
    test_clk_div1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
